// File: rtl/hci_parity_fault_collector_pkg.sv
// Shared types for the HCI parity fault collector: alarm FSM states and alarm payload.
`ifndef HCI_FC_IDX_W
`define HCI_FC_IDX_W 2
`endif

package hci_parity_fault_collector_pkg;

  localparam int HCI_FC_IDX_W = `HCI_FC_IDX_W;

  typedef enum logic {HCI_FC_IDLE, HCI_FC_ALARM} hci_fault_coll_state_e;

  typedef logic [HCI_FC_IDX_W-1:0] hci_fc_idx_t;

  typedef struct packed {
    hci_fc_idx_t idx;
    logic        multi;
  } hci_fault_alarm_t;

endpackage

// File: rtl/hci_fault_prio_enc.sv
// Lowest-set-bit encoder with a more-than-one-bit-set flag over a sink fault vector.
module hci_fault_prio_enc #(
  parameter int N_SINKS = 4,
  parameter int IDX_W   = 2
) (
  input  logic [N_SINKS-1:0] vec,
  output logic [IDX_W-1:0]   idx,
  output logic               multi
);

  always_comb begin
    idx = '0;
    // Walk downward so the lowest set bit wins.
    for (int i = N_SINKS - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    multi = ($countones(vec) > 1);
  end

endmodule

// File: rtl/hci_parity_fault_collector.sv
// Collects parity-sink fault flags into sticky status, a saturating count, a fatal flag
// and a valid/ready alarm channel that never drops a fault cycle.
//
// state        | meaning
// HCI_FC_IDLE  | no event outstanding, alarm_valid_o low
// HCI_FC_ALARM | event presented, later faults accumulate in pending until handshake
module hci_parity_fault_collector
  import hci_parity_fault_collector_pkg::*;
#(
  parameter int unsigned N_SINKS      = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned FATAL_THRESH = 16,
  localparam int unsigned IDX_W       = (N_SINKS > 1) ? $clog2(N_SINKS) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic [N_SINKS-1:0] mask_i,
  input  logic [N_SINKS-1:0] fault_i,
  output logic               alarm_valid_o,
  input  logic               alarm_ready_i,
  output logic [IDX_W-1:0]   alarm_idx_o,
  output logic               alarm_multi_o,
  output logic [N_SINKS-1:0] status_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               fatal_o
);

  hci_fault_coll_state_e state_q, state_d, state_b;
  hci_fault_alarm_t      alarm_q, alarm_d;
  logic [N_SINKS-1:0]    fault_q;
  logic [N_SINKS-1:0]    status_q, status_d, status_b;
  logic [N_SINKS-1:0]    pending_q, pending_d, pending_b;
  logic [CNT_W-1:0]      count_q, count_d, count_b;
  logic                  fatal_q, fatal_d, fatal_b;
  logic                  any_fault;
  logic [N_SINKS-1:0]    enc_vec;
  logic [IDX_W-1:0]      enc_idx;
  logic                  enc_multi;

  // In IDLE pending is always empty, so one encoder serves both capture and reload.
  hci_fault_prio_enc #(
    .N_SINKS (int'(N_SINKS)),
    .IDX_W   (int'(IDX_W))
  ) u_prio_enc (
    .vec   (enc_vec),
    .idx   (enc_idx),
    .multi (enc_multi)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fault_q   <= '0;
      status_q  <= '0;
      pending_q <= '0;
      count_q   <= '0;
      fatal_q   <= 1'b0;
      alarm_q   <= '0;
      state_q   <= HCI_FC_IDLE;
    end else begin
      fault_q   <= fault_i & ~mask_i;
      status_q  <= status_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      fatal_q   <= fatal_d;
      alarm_q   <= alarm_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    // Clear wipes the held state first; the fault already in fault_q is then applied.
    status_b  = clear_i ? '0 : status_q;
    pending_b = clear_i ? '0 : pending_q;
    count_b   = clear_i ? '0 : count_q;
    fatal_b   = clear_i ? 1'b0 : fatal_q;
    state_b   = clear_i ? HCI_FC_IDLE : state_q;

    any_fault = |fault_q;
    status_d  = status_b | fault_q;

    count_d = count_b;
    if (any_fault && (count_b != '1)) count_d = count_b + CNT_W'(1);

    fatal_d = fatal_b | ((FATAL_THRESH != 0) && (32'(count_d) >= FATAL_THRESH));

    enc_vec   = pending_b | fault_q;
    state_d   = state_b;
    pending_d = pending_b;
    alarm_d   = alarm_q;

    case (state_b)
      HCI_FC_IDLE: begin
        if (any_fault) begin
          alarm_d.idx   = hci_fc_idx_t'(enc_idx);
          alarm_d.multi = enc_multi;
          state_d       = HCI_FC_ALARM;
        end
      end
      HCI_FC_ALARM: begin
        if (alarm_ready_i) begin
          pending_d = '0;
          if (|enc_vec) begin
            alarm_d.idx   = hci_fc_idx_t'(enc_idx);
            alarm_d.multi = enc_multi;
          end else begin
            state_d = HCI_FC_IDLE;
          end
        end else begin
          pending_d = enc_vec;
        end
      end
      default: state_d = HCI_FC_IDLE;
    endcase
  end

  assign alarm_valid_o = (state_q == HCI_FC_ALARM);
  assign alarm_idx_o   = IDX_W'(alarm_q.idx);
  assign alarm_multi_o = alarm_q.multi;
  assign status_o      = status_q;
  assign count_o       = count_q;
  assign fatal_o       = fatal_q;

endmodule

// File: tb/tb_hci_parity_fault_collector.sv
// Directed and random checks of the parity fault collector against an event-level model.
module tb_hci_parity_fault_collector;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       clear_i = 1'b0;
  logic [3:0] mask_i = '0;
  logic [3:0] fault_i = '0;
  logic       alarm_ready_i = 1'b0;
  logic       alarm_valid_o;
  logic [1:0] alarm_idx_o;
  logic       alarm_multi_o;
  logic [3:0] status_o;
  logic [3:0] count_o;
  logic       fatal_o;

  int n_checks = 0;
  int n_err    = 0;

  // Model state: registered input stage, sticky outputs, presented and pending fault sets.
  logic [3:0] m_fq, m_status, m_pay, m_pend;
  int         m_count;
  logic       m_fatal, m_valid;

  hci_parity_fault_collector #(
    .N_SINKS      (4),
    .CNT_W        (4),
    .FATAL_THRESH (5)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .mask_i        (mask_i),
    .fault_i       (fault_i),
    .alarm_valid_o (alarm_valid_o),
    .alarm_ready_i (alarm_ready_i),
    .alarm_idx_o   (alarm_idx_o),
    .alarm_multi_o (alarm_multi_o),
    .status_o      (status_o),
    .count_o       (count_o),
    .fatal_o       (fatal_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] f, input logic [3:0] m, input logic rdy,
                            input logic clr, input logic r);
    logic [3:0] merged;
    logic       hs;
    if (r) begin
      m_fq = '0; m_status = '0; m_pay = '0; m_pend = '0;
      m_count = 0; m_fatal = 1'b0; m_valid = 1'b0;
      return;
    end
    hs = m_valid && rdy;
    if (clr) begin
      m_status = '0; m_count = 0; m_fatal = 1'b0; m_pend = '0; m_valid = 1'b0; hs = 1'b0;
    end
    m_status = m_status | m_fq;
    if (m_fq != 0 && m_count < 15) m_count++;
    if (m_count >= 5) m_fatal = 1'b1;
    if (!m_valid) begin
      if (m_fq != 0) begin
        m_valid = 1'b1;
        m_pay   = m_fq;
      end
    end else if (hs) begin
      merged = m_pend | m_fq;
      m_pend = '0;
      if (merged != 0) m_pay = merged;
      else m_valid = 1'b0;
    end else begin
      m_pend = m_pend | m_fq;
    end
    m_fq = f & ~m;
  endtask

  task automatic cmp_model();
    chk("valid", alarm_valid_o, m_valid);
    chk("status", status_o, m_status);
    chk("count", count_o, m_count);
    chk("fatal", fatal_o, m_fatal);
    if (m_valid) begin
      chk("idx", alarm_idx_o, lowest(m_pay));
      chk("multi", alarm_multi_o, ($countones(m_pay) > 1));
    end
  endtask

  task automatic step(input logic [3:0] f, input logic [3:0] m, input logic rdy,
                      input logic clr, input logic r);
    @(negedge clk_i);
    fault_i = f; mask_i = m; alarm_ready_i = rdy; clear_i = clr; rst_i = r;
    @(posedge clk_i);
    model_edge(f, m, rdy, clr, r);
    #1;
    cmp_model();
  endtask

  initial begin
    // Reset
    step(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    step(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", alarm_valid_o, 1'b0);
    chk("rst_idx", alarm_idx_o, 2'd0);
    chk("rst_multi", alarm_multi_o, 1'b0);
    chk("rst_status", status_o, 4'h0);
    chk("rst_count", count_o, 4'd0);
    chk("rst_fatal", fatal_o, 1'b0);
    step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Single pulse on sink 1
    step(4'b0010, 4'h0, 1'b1, 1'b0, 1'b0);
    step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("pulse_valid", alarm_valid_o, 1'b1);
    chk("pulse_idx", alarm_idx_o, 2'd1);
    chk("pulse_multi", alarm_multi_o, 1'b0);
    chk("pulse_count", count_o, 4'd1);
    chk("pulse_status", status_o, 4'b0010);
    step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("pulse_idle", alarm_valid_o, 1'b0);

    // Simultaneous sinks 1 and 3
    step(4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    step(4'b1010, 4'h0, 1'b1, 1'b0, 1'b0);
    step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("simul_idx", alarm_idx_o, 2'd1);
    chk("simul_multi", alarm_multi_o, 1'b1);
    chk("simul_count", count_o, 4'd1);
    step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Backpressure: sink 3 then sink 0 while ready is low
    step(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    step(4'b1000, 4'h0, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 4'h0, 1'b0, 1'b0, 1'b0);
    step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("bp_hold_idx", alarm_idx_o, 2'd3);
    step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("bp_reload_valid", alarm_valid_o, 1'b1);
    chk("bp_reload_idx", alarm_idx_o, 2'd0);
    chk("bp_reload_multi", alarm_multi_o, 1'b0);
    step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("bp_done_valid", alarm_valid_o, 1'b0);
    chk("bp_count", count_o, 4'd2);

    // Saturation and fatal threshold
    step(4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(4'b0001, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("sat_count", count_o, 4'd15);
    chk("sat_fatal", fatal_o, 1'b1);

    // Clear colliding with a new fault while fatal is set
    step(4'b0100, 4'h0, 1'b1, 1'b0, 1'b0);
    step(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("clr_fatal", fatal_o, 1'b0);
    chk("clr_count", count_o, 4'd1);
    chk("clr_status", status_o, 4'b0100);
    chk("clr_valid", alarm_valid_o, 1'b1);
    chk("clr_idx", alarm_idx_o, 2'd2);
    step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Masked sink produces nothing
    step(4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    step(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
    step(4'h0, 4'b0001, 1'b1, 1'b0, 1'b0);
    chk("mask_status", status_o, 4'h0);
    chk("mask_count", count_o, 4'd0);
    chk("mask_valid", alarm_valid_o, 1'b0);

    // Reset in ALARM with a pending event
    step(4'b0001, 4'h0, 1'b0, 1'b0, 1'b0);
    step(4'b0100, 4'h0, 1'b0, 1'b0, 1'b0);
    step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    chk("rst2_valid", alarm_valid_o, 1'b0);
    chk("rst2_status", status_o, 4'h0);
    chk("rst2_count", count_o, 4'd0);
    step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("rst2_no_pending", alarm_valid_o, 1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 149) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
